// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing the bridge's AHB slave port among several masters.
// Grants move only at IDLE/NONSEQ boundaries, honour locked sequences and cap unlocked hold time.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int MASTER_W    = 2,
    parameter int MAX_HOLD    = 4
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic                   Hreadyout,
    input  logic [1:0]             Htrans,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MASTER_W-1:0]    Hmaster,
    output logic [MASTER_W-1:0]    Hmaster_d,
    output logic                   Hmastlock
);

    localparam logic [1:0] ST_PARK    = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int HOLD_W = 4;

    logic [1:0]             state_reg, state_next;
    logic [HOLD_W-1:0]      hold_reg, hold_next, hold_inc;
    logic [MASTER_W-1:0]    owner_reg, owner_next, winner;
    logic [MASTER_W-1:0]    master_d_reg;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next, other_req;
    logic                   mastlock_reg;
    logic                   arb_ok, any_req, any_other, own_req, own_lock, keep_ok;

    assign arb_ok    = Hreadyout & ((Htrans == HTRANS_IDLE) | (Htrans == HTRANS_NONSEQ));
    assign any_req   = |Hbusreq;
    assign any_other = |other_req;
    // grant_reg is always the one-hot of owner_reg, so it doubles as the owner select mask
    assign own_req   = |(Hbusreq & grant_reg);
    assign own_lock  = |(Hlock & grant_reg);

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_per_master
        assign other_req[gi]  = Hbusreq[gi] & (owner_reg != MASTER_W'(gi));
        assign grant_next[gi] = (owner_next == MASTER_W'(gi));
    end

    // Search downward so the nearest requester after the owner is written last and wins
    always_comb begin : winner_search
        int                     idx;
        logic [NUM_MASTERS-1:0] req_sh;
        idx    = 0;
        req_sh = '0;
        winner = owner_reg;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(owner_reg) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            req_sh = Hbusreq >> idx;
            if (req_sh[0]) begin
                winner = MASTER_W'(idx);
            end
        end
    end

    // Saturating at MAX_HOLD keeps long bursts from wrapping the counter
    always_comb begin
        hold_inc = '0;
        if (any_other) begin
            hold_inc = (hold_reg < HOLD_W'(MAX_HOLD)) ? hold_reg + 1'b1 : hold_reg;
        end
        keep_ok = own_req & (~any_other | (hold_inc < HOLD_W'(MAX_HOLD)));
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_PARK: begin
                if (arb_ok && any_req) begin
                    state_next = ST_GRANTED;
                    owner_next = winner;
                    hold_next  = '0;
                end
            end
            ST_GRANTED: begin
                hold_next = hold_inc;
                if (arb_ok) begin
                    if (own_lock && own_req) begin
                        state_next = ST_LOCKED;
                    end else if (!any_req) begin
                        state_next = ST_PARK;
                        owner_next = '0;
                        hold_next  = '0;
                    end else if (!keep_ok) begin
                        owner_next = winner;
                        hold_next  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (arb_ok && !own_lock) begin
                    hold_next  = '0;
                    state_next = ST_GRANTED;
                    if (!any_req) begin
                        state_next = ST_PARK;
                        owner_next = '0;
                    end else if (!keep_ok) begin
                        owner_next = winner;
                    end
                end
            end
            default: begin
                state_next = ST_PARK;
                owner_next = '0;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            state_reg    <= ST_PARK;
            owner_reg    <= '0;
            grant_reg    <= NUM_MASTERS'(1);
            master_d_reg <= '0;
            mastlock_reg <= 1'b0;
            hold_reg     <= '0;
        end else if (Hreadyout) begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            grant_reg    <= grant_next;
            master_d_reg <= owner_reg;
            mastlock_reg <= (state_next == ST_LOCKED);
            hold_reg     <= hold_next;
        end
    end

    assign Hgrant    = grant_reg;
    assign Hmaster   = owner_reg;
    assign Hmaster_d = master_d_reg;
    assign Hmastlock = mastlock_reg;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against a transfer-level reference model.
module tb_ahb_rr_arbiter;

    localparam int NM = 3;
    localparam int MW = 2;
    localparam int MH = 4;

    logic          Hclk;
    logic          Hresetn;
    logic [NM-1:0] Hbusreq;
    logic [NM-1:0] Hlock;
    logic          Hreadyout;
    logic [1:0]    Htrans;
    logic [NM-1:0] Hgrant;
    logic [MW-1:0] Hmaster;
    logic [MW-1:0] Hmaster_d;
    logic          Hmastlock;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: who owns the bus, whether it is parked or locked, transfers held
    int m_owner, m_owner_d, m_hold;
    bit m_park, m_lock;

    ahb_rr_arbiter #(.NUM_MASTERS(NM), .MASTER_W(MW), .MAX_HOLD(MH)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Hreadyout (Hreadyout),
        .Htrans    (Htrans),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmaster_d (Hmaster_d),
        .Hmastlock (Hmastlock)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    function automatic bit bit_of(input logic [NM-1:0] v, input int i);
        logic [NM-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // next requester in circular order after the current owner
    function automatic int pick_next(input int owner, input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++) begin
            if (bit_of(req, (owner + k) % NM)) return (owner + k) % NM;
        end
        return owner;
    endfunction

    task automatic model_step();
        int others, h, w;
        bit own_req, own_lock, any, boundary;
        if (Hresetn) begin
            m_owner = 0; m_owner_d = 0; m_hold = 0; m_park = 1; m_lock = 0;
            return;
        end
        if (!Hreadyout) return;
        m_owner_d = m_owner;
        boundary  = (Htrans == 2'b00) || (Htrans == 2'b10);
        others = 0;
        for (int i = 0; i < NM; i++) begin
            if (i != m_owner && bit_of(Hbusreq, i)) others++;
        end
        own_req  = bit_of(Hbusreq, m_owner);
        own_lock = bit_of(Hlock, m_owner);
        any      = own_req || (others > 0);
        h        = (others > 0) ? m_hold + 1 : 0;
        w        = pick_next(m_owner, Hbusreq);
        if (m_park) begin
            if (boundary && any) begin
                m_park = 0; m_owner = w; m_hold = 0;
            end
        end else if (m_lock) begin
            if (boundary && !own_lock) begin
                m_lock = 0; m_hold = 0;
                if (!any) begin
                    m_park = 1; m_owner = 0;
                end else if (!(own_req && (others == 0 || h < MH))) begin
                    m_owner = w;
                end
            end
        end else begin
            m_hold = h;
            if (boundary) begin
                if (own_lock && own_req) begin
                    m_lock = 1;
                end else if (!any) begin
                    m_park = 1; m_owner = 0; m_hold = 0;
                end else if (!(own_req && (others == 0 || h < MH))) begin
                    m_owner = w; m_hold = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge Hclk);
        model_step();
        #1;
        check({tag, "_grant"},    32'(Hgrant),    32'(1) << m_owner);
        check({tag, "_master"},   32'(Hmaster),   32'(m_owner));
        check({tag, "_master_d"}, 32'(Hmaster_d), 32'(m_owner_d));
        check({tag, "_mastlock"}, 32'(Hmastlock), 32'(m_lock));
        $display("[%0t] %-12s req=%b lock=%b rdy=%b trans=%b -> grant=%b master=%0d master_d=%0d mastlock=%b",
                 $time, tag, Hbusreq, Hlock, Hreadyout, Htrans, Hgrant, Hmaster, Hmaster_d, Hmastlock);
    endtask

    initial begin
        m_owner = 0; m_owner_d = 0; m_hold = 0; m_park = 1; m_lock = 0;

        // reset must win over busy inputs
        Hresetn = 1'b1; Hbusreq = 3'b111; Hlock = 3'b111; Hreadyout = 1'b1; Htrans = 2'b10;
        repeat (2) cycle("reset");
        Hresetn = 1'b0; Hbusreq = 3'b000; Hlock = 3'b000; Htrans = 2'b00;
        repeat (3) cycle("park");

        Hbusreq = 3'b010;
        repeat (2) cycle("single");

        Hbusreq = 3'b111; Htrans = 2'b10;
        repeat (30) cycle("fair");

        // burst protection followed by a stall
        Hbusreq = 3'b010; Htrans = 2'b00;
        cycle("burst_setup");
        Hbusreq = 3'b101; Htrans = 2'b11;
        repeat (6) cycle("burst_seq");
        Hreadyout = 1'b0;
        repeat (3) cycle("stall");
        Hreadyout = 1'b1; Htrans = 2'b10;
        repeat (2) cycle("burst_end");

        // locked sequence on master 2, then release with master 2 idle
        Hbusreq = 3'b100; Htrans = 2'b00;
        cycle("lock_setup");
        Hbusreq = 3'b111; Hlock = 3'b100; Htrans = 2'b10;
        repeat (10) cycle("locked");
        Hlock = 3'b000; Hbusreq = 3'b011;
        repeat (2) cycle("unlock");

        // reset while master 1 is locked and mid-burst
        Hbusreq = 3'b010; Htrans = 2'b00;
        cycle("mid_setup");
        Hbusreq = 3'b111; Hlock = 3'b010; Htrans = 2'b10;
        cycle("mid_lock");
        Htrans = 2'b11;
        repeat (2) cycle("mid_burst");
        Hresetn = 1'b1;
        cycle("mid_reset");
        Hresetn = 1'b0; Hlock = 3'b000;
        cycle("after_reset");

        repeat (600) begin
            Hresetn   = ($urandom_range(0, 59) == 0);
            Hreadyout = ($urandom_range(0, 3) != 0);
            Hbusreq   = 3'($urandom);
            Hlock     = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            Htrans    = 2'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
